// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle for fifo_wr_arbiter: requester valid/data/ready plus FIFO write pins and status.
// The arbiter connects through the slave modport; the environment (producers + FIFO) uses master.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      fifo_full;
  logic                      fifo_threshold;
  logic                      fifo_we;
  logic [DATA_W-1:0]         fifo_din;
  logic                      busy;
  logic [OWN_W-1:0]          owner;

  modport master (
    output req, req_data, fifo_full, fifo_threshold,
    input  gnt, fifo_we, fifo_din, busy, owner
  );

  modport slave (
    input  req, req_data, fifo_full, fifo_threshold,
    output gnt, fifo_we, fifo_din, busy, owner
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional stall statistics counter (stall_cnt port) is built when ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_wr_arbiter_if.slave arb
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int LIM_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [OWN_W-1:0]   owner_q;
  logic [LIM_W-1:0]   beat_cnt_q;
  logic [LIM_W-1:0]   burst_lim_q;

  logic [OWN_W-1:0]   pick;
  logic               any_req;
  logic               req_own;
  logic               beat;
  logic               last_beat;

  assign any_req   = |arb.req;
  assign req_own   = arb.req[owner_q];
  assign beat      = (state_q == BURST) && req_own && !arb.fifo_full;
  assign last_beat = (beat_cnt_q == burst_lim_q - LIM_W'(1));

  // Scan owner+1, owner+2, ... (mod NUM_REQ); the current owner is checked last.
  always_comb begin
    int               idx;
    logic [OWN_W-1:0] idx_w;
    logic             found;
    pick  = owner_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(owner_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = OWN_W'(idx);
      if (!found && arb.req[idx_w]) begin
        found = 1'b1;
        pick  = idx_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A dropped request releases immediately; fifo_full only pauses the burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BURST;
      BURST: begin
        if (!req_own)               state_d = IDLE;
        else if (beat && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arb.gnt      = '0;
    arb.fifo_we  = 1'b0;
    arb.fifo_din = '0;
    arb.busy     = 1'b0;
    case (state_q)
      BURST: begin
        arb.busy         = 1'b1;
        arb.gnt[owner_q] = ~arb.fifo_full;
        arb.fifo_we      = beat;
        if (beat) arb.fifo_din = arb.req_data[int'(owner_q)*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  assign arb.owner = owner_q;

  // Burst length is fixed at grant time; a threshold change mid-burst is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_W'(NUM_REQ - 1);
      beat_cnt_q  <= '0;
      burst_lim_q <= LIM_W'(BURST_LEN);
    end else if (state_q == IDLE && any_req) begin
      owner_q     <= pick;
      beat_cnt_q  <= '0;
      burst_lim_q <= arb.fifo_threshold ? LIM_W'(1) : LIM_W'(BURST_LEN);
    end else if (beat) begin
      beat_cnt_q  <= beat_cnt_q + LIM_W'(1);
    end
  end

`ifdef ARB_STATS_EN
  logic stall;
  assign stall = (state_q == BURST) && req_own && arb.fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    arb.fifo_we |-> !arb.fifo_full);
  a_gnt_onehot:  assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(arb.gnt));
  a_gnt_burst:   assert property (@(posedge clk) disable iff (!rst_n)
    (arb.gnt != '0) |-> (state_q == BURST));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer model drives requests, a scoreboard monitor checks every FIFO write.
// Define ARB_STATS_EN at build time to also check stall_cnt.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) arb ();

`ifdef ARB_STATS_EN
  logic [7:0] stall_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BURST_LEN(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb      (arb)
`ifdef ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] src_mem [NR][16];
  int         src_rd [NR];
  int         src_n  [NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_tests++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic add_src(input int r, input logic [7:0] d);
    src_mem[r][src_n[r]] = d;
    src_n[r]++;
  endtask

  task automatic add_exp(input int r, input logic [7:0] d);
    wr_t e;
    e.own  = 2'(r);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_rd[i] < src_n[i]) begin
        arb.req[i]                = 1'b1;
        arb.req_data[i*DW +: DW] = src_mem[i][src_rd[i]];
      end else begin
        arb.req[i]                = 1'b0;
        arb.req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // One clock: sample outputs on the falling edge, advance producers that saw valid&ready.
  task automatic cycle(output logic we_s, output logic [3:0] g_s, output logic bz_s,
                       output logic [1:0] own_s);
    logic [NR-1:0] b;
    @(negedge clk);
    we_s  = arb.fifo_we;
    g_s   = arb.gnt;
    bz_s  = arb.busy;
    own_s = arb.owner;
    b     = arb.gnt & arb.req;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (b[i]) src_rd[i]++;
    drive();
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_rd[i] = 0;
      src_n[i]  = 0;
    end
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    arb.fifo_full      = 1'b0;
    arb.fifo_threshold = 1'b0;
    clear_src();
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",   32'(arb.gnt), 32'h0);
    chk("rst_we",    32'(arb.fifo_we), 32'h0);
    chk("rst_din",   32'(arb.fifo_din), 32'h0);
    chk("rst_busy",  32'(arb.busy), 32'h0);
    chk("rst_owner", 32'(arb.owner), 32'(NR - 1));
    rst_n = 1'b1;
  endtask

  task automatic chk_drained(input string name);
    chk(name, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  // Scoreboard monitor plus per-cycle invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (arb.fifo_we) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: unexpected write data 0x%0h owner %0d at %0t",
                   arb.fifo_din, arb.owner, $time);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("sb_data",  32'(arb.fifo_din), 32'(e.data));
          chk("sb_owner", 32'(arb.owner), 32'(e.own));
        end
        chk("we_not_full", 32'(arb.fifo_full), 32'h0);
      end
      if (arb.gnt != '0) begin
        chk("gnt_onehot", 32'($onehot0(arb.gnt)), 32'h1);
        chk("gnt_busy",   32'(arb.busy), 32'h1);
      end
    end
  end

  initial begin
    logic       we, bz;
    logic [3:0] g;
    logic [1:0] own;
    logic [0:8] pat9;
    logic [0:9] pat10;
    logic [0:5] pat6;

    arb.req            = '0;
    arb.req_data       = '0;
    arb.fifo_full      = 1'b0;
    arb.fifo_threshold = 1'b0;

    // 1: single requester, two bursts with a bubble between.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      add_src(0, 8'hA1 + 8'(k));
      add_exp(0, 8'hA1 + 8'(k));
    end
    drive();
    pat9 = 9'b011110110;
    for (int c = 0; c < 9; c++) begin
      cycle(we, g, bz, own);
      chk("t1_we", 32'(we), 32'(pat9[c]));
      if (c < 8) chk("t1_gnt", 32'(g), pat9[c] ? 32'h1 : 32'h0);
    end
    chk_drained("t1_drain");

    // 2: all four requesting, round-robin 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < 8; k++) add_src(0, 8'h10 + 8'(k));
    for (int r = 1; r < 4; r++)
      for (int k = 0; k < 4; k++) add_src(r, 8'(16 * (r + 1) + k));
    for (int k = 0; k < 4; k++) add_exp(0, 8'h10 + 8'(k));
    for (int r = 1; r < 4; r++)
      for (int k = 0; k < 4; k++) add_exp(r, 8'(16 * (r + 1) + k));
    for (int k = 4; k < 8; k++) add_exp(0, 8'h10 + 8'(k));
    drive();
    for (int c = 0; c < 25; c++) begin
      cycle(we, g, bz, own);
      chk("t2_we",   32'(we), (c % 5 != 0) ? 32'h1 : 32'h0);
      chk("t2_busy", 32'(bz), (c % 5 != 0) ? 32'h1 : 32'h0);
    end
    chk_drained("t2_drain");

    // 3: owner 2 stalled by fifo_full for 3 cycles mid-burst.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      add_src(2, 8'h31 + 8'(k));
      add_exp(2, 8'h31 + 8'(k));
    end
    drive();
    pat9 = 9'b011000110;
    for (int c = 0; c < 9; c++) begin
      arb.fifo_full = (c >= 3 && c <= 5);
      cycle(we, g, bz, own);
      chk("t3_we", 32'(we), 32'(pat9[c]));
      if (c >= 3 && c <= 5) begin
        chk("t3_gnt_stall",   32'(g), 32'h0);
        chk("t3_owner_stall", 32'(own), 32'h2);
        chk("t3_busy_stall",  32'(bz), 32'h1);
      end
      if (c == 8) chk("t3_busy_end", 32'(bz), 32'h0);
    end
    arb.fifo_full = 1'b0;
`ifdef ARB_STATS_EN
    chk("t3_stall_cnt", 32'(stall_cnt), 32'h3);
`endif
    chk_drained("t3_drain");

    // 4: threshold high at grant -> single-beat bursts alternating 0,1.
    do_reset();
    arb.fifo_threshold = 1'b1;
    add_src(0, 8'h41); add_src(0, 8'h42);
    add_src(1, 8'h51); add_src(1, 8'h52);
    add_exp(0, 8'h41); add_exp(1, 8'h51); add_exp(0, 8'h42); add_exp(1, 8'h52);
    drive();
    for (int c = 0; c < 8; c++) begin
      cycle(we, g, bz, own);
      chk("t4_we", 32'(we), (c % 2 == 1) ? 32'h1 : 32'h0);
      if (c % 2 == 1) chk("t4_owner", 32'(own), 32'((c / 2) % 2));
    end
    chk_drained("t4_drain");

    // 4b: threshold rising mid-burst does not shorten the burst.
    arb.fifo_threshold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      add_src(0, 8'h45 + 8'(k));
      add_exp(0, 8'h45 + 8'(k));
    end
    drive();
    pat6 = 6'b011110;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) arb.fifo_threshold = 1'b1;
      cycle(we, g, bz, own);
      chk("t4b_we", 32'(we), 32'(pat6[c]));
    end
    arb.fifo_threshold = 1'b0;
    chk_drained("t4b_drain");

    // 5: owner 1 drops req after 2 beats; requester 3 is granted next.
    do_reset();
    add_src(1, 8'h61); add_src(1, 8'h62);
    for (int k = 0; k < 4; k++) add_src(3, 8'h81 + 8'(k));
    add_exp(1, 8'h61); add_exp(1, 8'h62);
    for (int k = 0; k < 4; k++) add_exp(3, 8'h81 + 8'(k));
    drive();
    pat10 = 10'b0110011110;
    for (int c = 0; c < 10; c++) begin
      cycle(we, g, bz, own);
      chk("t5_we", 32'(we), 32'(pat10[c]));
      if (c == 1) chk("t5_owner1", 32'(own), 32'h1);
      if (c == 3) chk("t5_busy_drop", 32'(bz), 32'h1);
      if (c == 4) chk("t5_busy_idle", 32'(bz), 32'h0);
      if (c == 5) chk("t5_owner3", 32'(own), 32'h3);
    end
    chk_drained("t5_drain");

    // 6: asynchronous reset mid-burst, then requester 0 wins first.
    do_reset();
    for (int k = 0; k < 4; k++) add_src(0, 8'h91 + 8'(k));
    add_exp(0, 8'h91); add_exp(0, 8'h92);
    drive();
    for (int c = 0; c < 3; c++) cycle(we, g, bz, own);
    chk("t6_busy_pre", 32'(arb.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_gnt_async",   32'(arb.gnt), 32'h0);
    chk("t6_we_async",    32'(arb.fifo_we), 32'h0);
    chk("t6_busy_async",  32'(arb.busy), 32'h0);
    chk("t6_owner_async", 32'(arb.owner), 32'h3);
    chk_drained("t6_drain_a");
    clear_src();
    for (int r = 0; r < 4; r++) begin
      add_src(r, 8'hA0 + 8'(r));
      add_exp(r, 8'hA0 + 8'(r));
    end
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) cycle(we, g, bz, own);
    chk_drained("t6_drain_b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
